// File: rtl/vending_controller_n.sv
// Vending transaction controller for N_ITEMS products: credit, per-item stock and prices,
// with cancel/refund, inactivity timeout, sold-out handling and coin rejection.
module vending_controller_n #(
  parameter int N_ITEMS = 4,
  parameter int PRICE_W = 8,
  parameter int STOCK_W = 4,
  parameter logic [N_ITEMS*PRICE_W-1:0] PRICES = {8'd75, 8'd50, 8'd35, 8'd25},
  parameter int INIT_STOCK = 5,
  parameter int TIMEOUT = 250_000_000,
  localparam int SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       coin_5,
  input  logic                       coin_10,
  input  logic                       coin_25,
  input  logic                       next_item,
  input  logic                       select,
  input  logic                       cancel,
  input  logic                       restock,
  output logic                       dispense,
  output logic [SEL_W-1:0]           dispense_item,
  output logic [PRICE_W-1:0]         change,
  output logic                       change_valid,
  output logic [SEL_W-1:0]           selected_item,
  output logic [1:0]                 state,
  output logic [PRICE_W-1:0]         total,
  output logic                       sold_out,
  output logic                       deny,
  output logic                       coin_reject,
  output logic [N_ITEMS*STOCK_W-1:0] stock_flat
);
  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [PRICE_W:0] CREDIT_MAX = {1'b0, {PRICE_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    VEND    = 2'b10,
    REFUND  = 2'b11
  } state_t;

  state_t               state_q, state_d;
  logic [PRICE_W-1:0]   total_q, total_d, change_q, change_d;
  logic [SEL_W-1:0]     sel_q, sel_d, ditem_q, ditem_d;
  logic                 disp_q, disp_d, cv_q, cv_d;
  logic                 so_q, so_d, deny_q, deny_d, rej_q, rej_d;
  logic [STOCK_W-1:0]   stock_q [N_ITEMS];
  logic [STOCK_W-1:0]   stock_d [N_ITEMS];
  logic [TMR_W-1:0]     timer_q, timer_d;

  logic [PRICE_W-1:0]   coin_val, price_sel;
  logic [PRICE_W:0]     eff;
  logic                 coin_open, coin_ok, any_event;
  logic [1:0]           coin_cnt;

  // eff is the credit every same-cycle decision sees, so an accepted coin is never lost.
  always_comb begin
    coin_val = '0;
    if (coin_25)      coin_val = PRICE_W'(25);
    else if (coin_10) coin_val = PRICE_W'(10);
    else if (coin_5)  coin_val = PRICE_W'(5);
    coin_open = (state_q == IDLE) || (state_q == COLLECT);
    coin_ok   = coin_open && (coin_val != '0) &&
                (({1'b0, total_q} + {1'b0, coin_val}) <= CREDIT_MAX);
    eff       = {1'b0, total_q} + (coin_ok ? {1'b0, coin_val} : '0);
    coin_cnt  = {1'b0, coin_5} + {1'b0, coin_10} + {1'b0, coin_25};
    any_event = coin_5 | coin_10 | coin_25 | next_item | select | cancel;
    price_sel = PRICES[sel_q*PRICE_W +: PRICE_W];
  end

  always_comb begin
    state_d  = state_q;
    total_d  = total_q;
    change_d = change_q;
    sel_d    = sel_q;
    ditem_d  = ditem_q;
    disp_d   = 1'b0;
    cv_d     = 1'b0;
    so_d     = 1'b0;
    deny_d   = 1'b0;
    rej_d    = coin_cnt > {1'b0, coin_ok};
    stock_d  = stock_q;
    case (state_q)
      IDLE, COLLECT: begin
        if (cancel) begin
          if (state_q == COLLECT || eff != '0) begin
            state_d  = REFUND;
            change_d = eff[PRICE_W-1:0];
            cv_d     = 1'b1;
            total_d  = '0;
          end
        end else if (select) begin
          if (stock_q[sel_q] == '0 || eff < {1'b0, price_sel}) begin
            so_d    = (stock_q[sel_q] == '0);
            deny_d  = (stock_q[sel_q] != '0);
            total_d = eff[PRICE_W-1:0];
            if (eff != '0) state_d = COLLECT;
          end else begin
            state_d        = VEND;
            disp_d         = 1'b1;
            ditem_d        = sel_q;
            change_d       = PRICE_W'(eff - {1'b0, price_sel});
            cv_d           = 1'b1;
            total_d        = '0;
            stock_d[sel_q] = stock_q[sel_q] - STOCK_W'(1);
          end
        end else if (coin_ok) begin
          state_d = COLLECT;
          total_d = eff[PRICE_W-1:0];
        end else if (next_item) begin
          sel_d = (sel_q == SEL_W'(N_ITEMS - 1)) ? '0 : sel_q + SEL_W'(1);
        end else if (restock && state_q == IDLE) begin
          for (int i = 0; i < N_ITEMS; i++) stock_d[i] = STOCK_W'(INIT_STOCK);
        end else if (state_q == COLLECT && !any_event && timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d  = REFUND;
          change_d = total_q;
          cv_d     = 1'b1;
          total_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Idle counter only runs while staying in COLLECT with no front-panel activity.
    timer_d = (state_q == COLLECT && state_d == COLLECT && !any_event) ?
              timer_q + TMR_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      total_q  <= '0;
      change_q <= '0;
      sel_q    <= '0;
      ditem_q  <= '0;
      disp_q   <= 1'b0;
      cv_q     <= 1'b0;
      so_q     <= 1'b0;
      deny_q   <= 1'b0;
      rej_q    <= 1'b0;
      timer_q  <= '0;
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      state_q  <= state_d;
      total_q  <= total_d;
      change_q <= change_d;
      sel_q    <= sel_d;
      ditem_q  <= ditem_d;
      disp_q   <= disp_d;
      cv_q     <= cv_d;
      so_q     <= so_d;
      deny_q   <= deny_d;
      rej_q    <= rej_d;
      timer_q  <= timer_d;
      stock_q  <= stock_d;
    end
  end

  for (genvar i = 0; i < N_ITEMS; i++) begin : g_flat
    assign stock_flat[i*STOCK_W +: STOCK_W] = stock_q[i];
  end

  assign state         = state_q;
  assign total         = total_q;
  assign change        = change_q;
  assign change_valid  = cv_q;
  assign selected_item = sel_q;
  assign dispense      = disp_q;
  assign dispense_item = ditem_q;
  assign sold_out      = so_q;
  assign deny          = deny_q;
  assign coin_reject   = rej_q;

endmodule

// File: tb/tb_vending_controller_n.sv
// Directed bench for vending_controller_n: behavioural model checked every cycle plus
// hand-computed literal expectations for the main scenarios.
module tb_vending_controller_n;
  localparam int N = 4;
  localparam int TMO = 20;
  localparam logic [7:0] RST = 8'h01, C5 = 8'h02, C10 = 8'h04, C25 = 8'h08;
  localparam logic [7:0] NXT = 8'h10, SEL = 8'h20, CAN = 8'h40, RSK = 8'h80;

  logic clk = 1'b0;
  logic reset = 1'b0, coin_5 = 1'b0, coin_10 = 1'b0, coin_25 = 1'b0;
  logic next_item = 1'b0, select = 1'b0, cancel = 1'b0, restock = 1'b0;
  logic dispense, change_valid, sold_out, deny, coin_reject;
  logic [1:0]  dispense_item, selected_item, state;
  logic [7:0]  change, total;
  logic [15:0] stock_flat;

  vending_controller_n #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .coin_5(coin_5), .coin_10(coin_10), .coin_25(coin_25),
    .next_item(next_item), .select(select), .cancel(cancel), .restock(restock),
    .dispense(dispense), .dispense_item(dispense_item), .change(change),
    .change_valid(change_valid), .selected_item(selected_item), .state(state),
    .total(total), .sold_out(sold_out), .deny(deny), .coin_reject(coin_reject),
    .stock_flat(stock_flat)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: credit in cents, state as 0 idle / 1 collect / 2 vend / 3 refund.
  int price [N] = '{25, 35, 50, 75};
  int m_state, m_total, m_sel, m_change, m_ditem, m_idle;
  int m_stock [N];
  bit m_disp, m_cv, m_so, m_dn, m_cr, m_valid = 1'b0;
  logic [7:0] exp_q [$];

  task automatic model_next(input logic [7:0] in);
    int val, nco, eff, prev;
    bit evt;
    if (in & RST) begin
      m_state = 0; m_total = 0; m_sel = 0; m_change = 0; m_ditem = 0; m_idle = 0;
      for (int i = 0; i < N; i++) m_stock[i] = 5;
      m_disp = 0; m_cv = 0; m_so = 0; m_dn = 0; m_cr = 0;
      exp_q.delete();
      m_valid = 1'b1;
      return;
    end
    m_disp = 0; m_cv = 0; m_so = 0; m_dn = 0;
    prev = m_state;
    val = 0;
    if (prev < 2) val = (in & C25) ? 25 : (in & C10) ? 10 : (in & C5) ? 5 : 0;
    if (m_total + val > 255) val = 0;
    nco = ((in & C5) != 0) + ((in & C10) != 0) + ((in & C25) != 0);
    m_cr = nco > ((val > 0) ? 1 : 0);
    eff = m_total + val;
    evt = (nco > 0) || ((in & (NXT | SEL | CAN)) != 0);
    if (prev >= 2) begin
      m_state = 0;
    end else if (in & CAN) begin
      if (prev == 1 || eff > 0) begin
        m_change = eff; m_cv = 1; m_total = 0; m_state = 3; exp_q.push_back(8'(eff));
      end
    end else if (in & SEL) begin
      if (m_stock[m_sel] == 0 || eff < price[m_sel]) begin
        if (m_stock[m_sel] == 0) m_so = 1; else m_dn = 1;
        m_total = eff;
        if (eff > 0) m_state = 1;
      end else begin
        m_disp = 1; m_ditem = m_sel; m_change = eff - price[m_sel]; m_cv = 1;
        m_stock[m_sel]--; m_total = 0; m_state = 2; exp_q.push_back(8'(m_change));
      end
    end else if (val > 0) begin
      m_total = eff; m_state = 1;
    end else if (in & NXT) begin
      m_sel = (m_sel + 1) % N;
    end else if ((in & RSK) && prev == 0) begin
      for (int i = 0; i < N; i++) m_stock[i] = 5;
    end else if (prev == 1 && !evt && m_idle == TMO - 1) begin
      m_change = m_total; m_cv = 1; m_total = 0; m_state = 3; exp_q.push_back(8'(m_change));
    end
    m_idle = (prev == 1 && m_state == 1 && !evt) ? m_idle + 1 : 0;
  endtask

  task automatic step(input logic [7:0] in);
    @(negedge clk);
    reset = in[0]; coin_5 = in[1]; coin_10 = in[2]; coin_25 = in[3];
    next_item = in[4]; select = in[5]; cancel = in[6]; restock = in[7];
    model_next(in);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: every output against the model, every cycle after the first reset.
  always @(posedge clk) begin
    logic [15:0] exp_stock;
    logic [7:0]  exp_chg;
    #1;
    if (m_valid) begin
      exp_stock = '0;
      for (int i = 0; i < N; i++) exp_stock[i*4 +: 4] = 4'(m_stock[i]);
      check("state", state, m_state);
      check("total", total, m_total);
      check("change", change, m_change);
      check("change_valid", change_valid, m_cv);
      check("selected_item", selected_item, m_sel);
      check("dispense", dispense, m_disp);
      check("sold_out", sold_out, m_so);
      check("deny", deny, m_dn);
      check("coin_reject", coin_reject, m_cr);
      check("stock_flat", stock_flat, exp_stock);
      if (m_disp) check("dispense_item", dispense_item, m_ditem);
      if (change_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("change_queue_unexpected", 1, 0);
        end else begin
          exp_chg = exp_q.pop_front();
          check("change_queue", change, exp_chg);
        end
      end
    end
  end

  initial begin
    int n;
    // Reset state
    step(RST);
    check("rst_state", state, 0);
    check("rst_total", total, 0);
    check("rst_stock", stock_flat, 16'h5555);
    check("rst_cv", change_valid, 0);

    // 3 x 25c then vend item 0 (25c): change 50
    step(C25); step(C25); step(C25);
    check("t1_total", total, 75);
    check("t1_state", state, 1);
    step(SEL);
    check("t1_dispense", dispense, 1);
    check("t1_change", change, 50);
    check("t1_state_vend", state, 2);
    check("t1_total_clr", total, 0);
    check("t1_stock0", stock_flat[3:0], 4);
    step(0);
    check("t1_idle", state, 0);

    // Insufficient credit for item 3, then cancel
    step(NXT); step(NXT); step(NXT);
    step(C25); step(C10);
    step(SEL);
    check("t2_deny", deny, 1);
    check("t2_total", total, 35);
    step(CAN);
    check("t2_refund_state", state, 3);
    check("t2_refund_change", change, 35);
    step(0);
    check("t2_idle", state, 0);
    step(NXT);
    check("t2_sel_wrap", selected_item, 0);

    // Drain item 1 with exact credit, then sold out and restock
    step(NXT);
    for (int k = 0; k < 5; k++) begin
      step(C25); step(C10); step(SEL);
      check("t3_dispense", dispense, 1);
      check("t3_change_exact", change, 0);
      step(0);
    end
    check("t3_stock_empty", stock_flat, 16'h5504);
    step(C25); step(C10); step(SEL);
    check("t3_sold_out", sold_out, 1);
    check("t3_credit_kept", total, 35);
    step(CAN); step(0);
    step(RSK);
    check("t3_restock", stock_flat, 16'h5555);

    // Simultaneous coins, credit ceiling
    step(C25 | C10);
    check("t4_total", total, 25);
    check("t4_reject", coin_reject, 1);
    for (int k = 0; k < 9; k++) step(C25);
    check("t4_total250", total, 250);
    step(C10);
    check("t4_ovf_reject", coin_reject, 1);
    check("t4_ovf_total", total, 250);
    step(C5);
    check("t4_total255", total, 255);
    step(CAN);
    check("t4_refund255", change, 255);
    step(0);

    // Coin and select together, coin during VEND
    step(NXT); step(NXT); step(NXT);
    step(C10); step(C5);
    step(C10 | SEL);
    check("t5_dispense", dispense, 1);
    check("t5_change0", change, 0);
    check("t5_cv", change_valid, 1);
    check("t5_item", dispense_item, 0);
    step(C5);
    check("t5_vend_reject", coin_reject, 1);
    check("t5_vend_total", total, 0);
    check("t5_vend_idle", state, 0);

    // Inactivity timeout
    step(C5);
    n = 0;
    while (state !== 2'b11 && n < 40) begin
      step(0);
      n++;
    end
    check("t6_timeout_cycles", n, TMO);
    check("t6_timeout_change", change, 5);
    check("t6_timeout_cv", change_valid, 1);
    step(0);

    // Reset mid-COLLECT discards credit silently
    step(C10); step(0); step(0); step(0);
    step(RST);
    check("t7_total", total, 0);
    check("t7_state", state, 0);
    check("t7_cv", change_valid, 0);
    step(0); step(0);

    check("queue_drained", exp_q.size(), 0);
    m_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
